serial_tx_feeder: RTL and testbench

Byte-buffering stage directly upstream of the UART transmitter. Accepts bytes from the system side into an internal FIFO and hands them one at a time to the transmitter over its `data`/`new_data`/`busy` interface, so producers can burst-write without waiting on the serial line. The transmitter's registered `busy` lags `new_data` by one cycle; this block's handshake state machine covers that gap so no byte is ever issued twice or dropped.

---
 rtl/serial_tx_feeder.sv | 71 +++++++
 tb/tb_serial_tx_feeder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_feeder.sv
// serial_tx_feeder: byte FIFO feeding a UART transmitter over a data/new_data/busy handshake.
module serial_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       wr_data,
  input  logic             wr_en,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic [7:0]       tx_data,
  output logic             tx_new_data,
  input  logic             tx_busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_BUSY = 2'd1, WAIT_DONE = 2'd2} state_t;
  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [2:0]       tmr;
  logic             pop, wr_ok;
  assign full  = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign pop   = !flush && state == IDLE && !empty && !tx_busy;
  // a pop in the same cycle frees a slot, so a write into a full FIFO is still taken
  assign wr_ok = !flush && wr_en && (!full || pop);
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      tx_data     <= 8'h00;
      tx_new_data <= 1'b0;
      tmr         <= '0;
    end else begin
      if (flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (wr_ok && !pop) count <= count + 1'b1;
        else if (pop && !wr_ok) count <= count - 1'b1;
        if (wr_en && !wr_ok) overflow <= 1'b1;
      end
      tx_new_data <= pop;
      if (pop) tx_data <= mem[rd_ptr];
      // busy is registered on the transmitter side, so wait for it to appear before trusting it
      case (state)
        IDLE: if (pop) begin
          state <= WAIT_BUSY;
          tmr   <= '0;
        end
        WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
          else if (tmr == 3'd4) state <= IDLE;
          else tmr <= tmr + 1'b1;
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx_feeder.sv
// tb_serial_tx_feeder: directed and randomized checks of serial_tx_feeder against a queue-based model.
module tb_serial_tx_feeder;
  localparam int DEPTH = 16;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       flush = 1'b0;
  logic       full, empty, overflow, tx_new_data, tx_busy;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       force_busy = 1'b0;
  logic       no_busy = 1'b0;
  int         busy_len = 10;
  int         bcnt = 0;
  int         cyc = 0;
  int         dbl = 0;
  int         viol = 0;
  logic       prev_nd = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] rx_q[$];
  int         st_q[$];
  logic [7:0] exp_q[$];

  serial_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_data(tx_data), .tx_new_data(tx_new_data), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // transmitter model: busy for busy_len cycles starting the cycle after a strobe
  assign tx_busy = force_busy || (bcnt != 0);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_new_data) begin
      rx_q.push_back(tx_data);
      st_q.push_back(cyc);
      if (tx_busy) viol <= viol + 1;
    end
    if (tx_new_data && prev_nd) dbl <= dbl + 1;
    prev_nd <= tx_new_data;
    if (tx_new_data && !no_busy) bcnt <= busy_len;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input bit expect_tx);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (expect_tx) exp_q.push_back(d);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (rx_q.size() < exp_q.size() && k < 2000) begin
      tick();
      k++;
    end
    chk({tag, "_drain_timeout"}, k < 2000, 1);
    repeat (20) tick();
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  task automatic clear_q();
    rx_q.delete();
    st_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_txdata"}, tx_data, 8'h00);
    chk({tag, "_newdata"}, tx_new_data, 0);
  endtask

  initial begin
    int min_gap, n, occ, k;
    logic [7:0] b;
    repeat (3) tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();
    // single byte latency
    busy_len = 10;
    wr(8'hA5, 1'b0);
    chk("lat_count1", count, 1);
    chk("lat_empty0", empty, 0);
    chk("lat_nd_early", tx_new_data, 0);
    tick();
    chk("lat_nd", tx_new_data, 1);
    chk("lat_data", tx_data, 8'hA5);
    chk("lat_count0", count, 0);
    tick();
    chk("lat_nd_once", tx_new_data, 0);
    chk("lat_empty1", empty, 1);
    repeat (20) tick();
    chk("lat_rx_count", rx_q.size(), 1);
    clear_q();
    // burst ordering with the transmitter held off until the FIFO is full
    busy_len = 3;
    force_busy = 1'b1;
    for (int i = 1; i <= 16; i++) wr(8'(i), 1'b1);
    chk("burst_full", full, 1);
    chk("burst_count", count, 16);
    force_busy = 1'b0;
    drain("burst");
    chk("burst_ovf", overflow, 0);
    min_gap = 1000;
    for (int i = 1; i < st_q.size(); i++)
      if (st_q[i] - st_q[i-1] < min_gap) min_gap = st_q[i] - st_q[i-1];
    chk("burst_spacing_ok", min_gap >= busy_len + 2, 1);
    clear_q();
    // overflow: 17th byte dropped
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) wr(8'h20 + 8'(i), i < 16);
    chk("ovf_count", count, 16);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    force_busy = 1'b0;
    drain("ovf");
    chk("ovf_sticky", overflow, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_ovf", overflow, 0);
    clear_q();
    // simultaneous write and pop while full
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i), 1'b1);
    chk("sim_full", full, 1);
    force_busy = 1'b0;
    wr(8'h50, 1'b1);
    chk("sim_count", count, 16);
    chk("sim_ovf", overflow, 0);
    chk("sim_first", tx_data, 8'h40);
    drain("sim");
    clear_q();
    // randomized traffic, 40 bytes through the 16-deep FIFO
    busy_len = 2;
    n = 0;
    k = 0;
    while (n < 40 && k < 5000) begin
      occ = exp_q.size() - rx_q.size();
      if ($urandom_range(0, 1) == 1 && occ < DEPTH) begin
        b = 8'($urandom);
        wr(b, 1'b1);
        n++;
      end else tick();
      k++;
    end
    drain("rand");
    chk("rand_ovf", overflow, 0);
    clear_q();
    // busy timeout path
    no_busy = 1'b1;
    wr(8'h77, 1'b1);
    wr(8'h88, 1'b1);
    drain("tmo");
    chk("tmo_strobes", st_q.size(), 2);
    if (st_q.size() == 2) chk("tmo_spacing", st_q[1] - st_q[0], 6);
    no_busy = 1'b0;
    clear_q();
    // blocked transmitter, then reset while waiting for busy to fall
    force_busy = 1'b1;
    wr(8'h91, 1'b0);
    wr(8'h92, 1'b0);
    wr(8'h93, 1'b0);
    repeat (5) tick();
    chk("blk_count", count, 3);
    chk("blk_nostrobe", rx_q.size(), 0);
    busy_len = 10;
    force_busy = 1'b0;
    k = 0;
    while (rx_q.size() < 1 && k < 50) begin
      tick();
      k++;
    end
    chk("blk_strobe_seen", rx_q.size(), 1);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk_reset("midrst");
    rst_n = 1'b1;
    repeat (30) tick();
    chk("midrst_rx_len", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("midrst_rx_byte", rx_q[0], 8'h91);
    chk("midrst_empty", empty, 1);
    chk("no_double_strobe", dbl, 0);
    chk("no_strobe_in_busy", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
